// File: rtl/gate_sweep_engine_if.sv
// Handshake and result bundle for the gate sweep engine.
// The requester drives start/mode; the engine returns the registered A/Y
// stream, the accumulated truth table (named truth_table because "table"
// is a reserved word), the ones count and its status flags.
interface gate_sweep_engine_if #(
  parameter int N = 2
);
  logic                 start;
  logic [2:0]           mode;
  logic [N-1:0]         A;
  logic                 Y;
  logic                 valid;
  logic [(1 << N)-1:0]  truth_table;
  logic [N:0]           ones;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, mode,
    input  A, Y, valid, truth_table, ones, busy, done, err
  );

  modport slave (
    input  start, mode,
    output A, Y, valid, truth_table, ones, busy, done, err
  );
endinterface

// File: rtl/gate_sweep_engine.sv
// Gate sweep engine: on start, walks every input combination of an N-input
// gate (AND/OR/NAND/NOR/XOR/XNOR), streaming one registered (A, Y) pair per
// cycle and building the truth table and ones count. Illegal modes (6, 7)
// finish immediately with err set and empty results.
module gate_sweep_engine #(
  parameter int N = 2
) (
  input logic                clk,
  input logic                rst,
  gate_sweep_engine_if.slave bus
);

  localparam int         W    = 1 << N;
  localparam logic [N:0] LAST = (N+1)'(W - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [N:0]   cnt;
  logic [2:0]   mode_q;
  logic [N-1:0] a_q;
  logic         y_q;
  logic         valid_q;
  logic [W-1:0] table_q;
  logic [N:0]   ones_q;
  logic         err_q;
  logic [N-1:0] idx;
  logic         gate_y;
  logic         mode_legal;

  assign idx        = cnt[N-1:0];
  assign mode_legal = (bus.mode <= 3'd5);

  // Gate result for the current index under the mode latched at start
  always_comb begin
    gate_y = 1'b0;
    case (mode_q)
      3'd0:    gate_y = &idx;
      3'd1:    gate_y = |idx;
      3'd2:    gate_y = ~(&idx);
      3'd3:    gate_y = ~(|idx);
      3'd4:    gate_y = ^idx;
      3'd5:    gate_y = ~(^idx);
      default: gate_y = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start is only heard outside SWEEP; sweep ends on the last index
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = mode_legal ? SWEEP : DONE;
      SWEEP:      if (cnt == LAST) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Datapath: latch the request on start, then emit one result per sweep cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        SWEEP: begin
          a_q          <= idx;
          y_q          <= gate_y;
          valid_q      <= 1'b1;
          table_q[idx] <= gate_y;
          ones_q       <= ones_q + (N+1)'(gate_y);
          cnt          <= cnt + (N+1)'(1);
        end
        default: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            table_q <= '0;
            ones_q  <= '0;
            cnt     <= '0;
            err_q   <= ~mode_legal;
          end
        end
      endcase
    end
  end

  // Outputs: status decoded from state, results straight from registers
  always_comb begin
    bus.busy        = (state == SWEEP);
    bus.done        = (state == DONE);
    bus.A           = a_q;
    bus.Y           = y_q;
    bus.valid       = valid_q;
    bus.truth_table = table_q;
    bus.ones        = ones_q;
    bus.err         = err_q;
  end

endmodule

// File: tb/tb_gate_sweep_engine.sv
// Bench for gate_sweep_engine: an N=2 and an N=3 instance share start/mode.
// Expected (A,Y) pairs are queued when a sweep is requested and compared
// against the pairs the monitor captured on each valid cycle.
module tb_gate_sweep_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;

  always #5 clk = ~clk;

  gate_sweep_engine_if #(.N(2)) bus2 ();
  gate_sweep_engine_if #(.N(3)) bus3 ();

  assign bus2.start = start;
  assign bus2.mode  = mode;
  assign bus3.start = start;
  assign bus3.mode  = mode;

  gate_sweep_engine #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  gate_sweep_engine #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic [2:0] mode;
    logic [3:0] tbl2;
    logic [2:0] ones2;
    logic [7:0] tbl3;
    logic [3:0] ones3;
    logic       err;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic       y;
  } pair_t;

  vec_t  vecs[9];
  pair_t q2[$];
  pair_t q3[$];

  int tests;
  int fails;

  // Monitor-owned capture rings and counters
  logic [2:0] obs2_a[64];
  logic       obs2_y[64];
  logic [2:0] obs3_a[64];
  logic       obs3_y[64];
  int valid2 = 0;
  int valid3 = 0;
  int busy2  = 0;
  int busy3  = 0;

  // Bench-owned bookkeeping
  int rd2, rd3;
  int base_v2, base_v3, base_b2, base_b3;
  int d2, d3;
  logic vd2, vd3;

  // Capture every valid pair and count busy cycles, away from the rising edge
  always @(negedge clk) begin
    if (bus2.valid) begin
      obs2_a[valid2 % 64] = 3'(bus2.A);
      obs2_y[valid2 % 64] = bus2.Y;
      valid2++;
    end
    if (bus3.valid) begin
      obs3_a[valid3 % 64] = bus3.A;
      obs3_y[valid3 % 64] = bus3.Y;
      valid3++;
    end
    if (bus2.busy) busy2++;
    if (bus3.busy) busy3++;
  end

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic void pushExpected(input vec_t v, input bit do2, input bit do3);
    pair_t p;
    if (do2) for (int i = 0; i < 4; i++) begin
      p.a = 3'(i);
      p.y = v.tbl2[i];
      q2.push_back(p);
    end
    if (do3) for (int i = 0; i < 8; i++) begin
      p.a = 3'(i);
      p.y = v.tbl3[i];
      q3.push_back(p);
    end
  endfunction

  // Compare every captured pair against the scoreboard, in order
  task automatic drain();
    pair_t p;
    while (rd2 < valid2) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL dut2 valid: got A=%0d, expected no valid", obs2_a[rd2 % 64]);
      end else begin
        p = q2.pop_front();
        check("dut2 A", 32'(obs2_a[rd2 % 64]), 32'(p.a));
        check("dut2 Y", 32'(obs2_y[rd2 % 64]), 32'(p.y));
      end
      rd2++;
    end
    while (rd3 < valid3) begin
      if (q3.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL dut3 valid: got A=%0d, expected no valid", obs3_a[rd3 % 64]);
      end else begin
        p = q3.pop_front();
        check("dut3 A", 32'(obs3_a[rd3 % 64]), 32'(p.a));
        check("dut3 Y", 32'(obs3_y[rd3 % 64]), 32'(p.y));
      end
      rd3++;
    end
  endtask

  task automatic checkReset();
    check("rst dut2 A",     32'(bus2.A), 0);
    check("rst dut2 Y",     32'(bus2.Y), 0);
    check("rst dut2 valid", 32'(bus2.valid), 0);
    check("rst dut2 table", 32'(bus2.truth_table), 0);
    check("rst dut2 ones",  32'(bus2.ones), 0);
    check("rst dut2 busy",  32'(bus2.busy), 0);
    check("rst dut2 done",  32'(bus2.done), 0);
    check("rst dut2 err",   32'(bus2.err), 0);
    check("rst dut3 A",     32'(bus3.A), 0);
    check("rst dut3 Y",     32'(bus3.Y), 0);
    check("rst dut3 valid", 32'(bus3.valid), 0);
    check("rst dut3 table", 32'(bus3.truth_table), 0);
    check("rst dut3 ones",  32'(bus3.ones), 0);
    check("rst dut3 busy",  32'(bus3.busy), 0);
    check("rst dut3 done",  32'(bus3.done), 0);
    check("rst dut3 err",   32'(bus3.err), 0);
  endtask

  // Called #1 after an edge; records cycles until each done is first seen
  task automatic waitDone();
    d2 = -1; d3 = -1; vd2 = 1'b0; vd3 = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (bus2.done && d2 < 0) begin d2 = c; vd2 = bus2.valid; end
      if (bus3.done && d3 < 0) begin d3 = c; vd3 = bus3.valid; end
      if (d2 >= 0 && d3 >= 0) break;
      @(posedge clk); #1;
    end
  endtask

  // One-cycle start pulse with the vector's mode, then wait for completion
  task automatic applyStimulus(input int vi);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = vecs[vi].mode;
    base_v2 = valid2; base_v3 = valid3; base_b2 = busy2; base_b3 = busy3;
    if (!vecs[vi].err) pushExpected(vecs[vi], 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
  endtask

  task automatic checkOutput(input int vi);
    vec_t v;
    v = vecs[vi];
    @(negedge clk); #1;
    drain();
    check("dut2 table",       32'(bus2.truth_table), 32'(v.tbl2));
    check("dut2 ones",        32'(bus2.ones), 32'(v.ones2));
    check("dut2 err",         32'(bus2.err), 32'(v.err));
    check("dut2 done",        32'(bus2.done), 1);
    check("dut2 done cycle",  32'(d2), v.err ? 0 : 4);
    check("dut2 valid@done",  32'(vd2), 32'(!v.err));
    check("dut2 valid count", 32'(valid2 - base_v2), v.err ? 0 : 4);
    check("dut2 busy cycles", 32'(busy2 - base_b2), v.err ? 0 : 4);
    check("dut3 table",       32'(bus3.truth_table), 32'(v.tbl3));
    check("dut3 ones",        32'(bus3.ones), 32'(v.ones3));
    check("dut3 err",         32'(bus3.err), 32'(v.err));
    check("dut3 done cycle",  32'(d3), v.err ? 0 : 8);
    check("dut3 valid@done",  32'(vd3), 32'(!v.err));
    check("dut3 valid count", 32'(valid3 - base_v3), v.err ? 0 : 8);
    check("dut3 busy cycles", 32'(busy3 - base_b3), v.err ? 0 : 8);
    check("dut2 queue left",  32'(q2.size()), 0);
    check("dut3 queue left",  32'(q3.size()), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] toggles[4];
    tests = 0; fails = 0; rd2 = 0; rd3 = 0;
    rst = 1'b1; start = 1'b0; mode = 3'd0;

    vecs[0] = '{3'd0, 4'b1000, 3'd1, 8'h80, 4'd1, 1'b0};
    vecs[1] = '{3'd1, 4'b1110, 3'd3, 8'hFE, 4'd7, 1'b0};
    vecs[2] = '{3'd2, 4'b0111, 3'd3, 8'h7F, 4'd7, 1'b0};
    vecs[3] = '{3'd3, 4'b0001, 3'd1, 8'h01, 4'd1, 1'b0};
    vecs[4] = '{3'd4, 4'b0110, 3'd2, 8'h96, 4'd4, 1'b0};
    vecs[5] = '{3'd5, 4'b1001, 3'd2, 8'h69, 4'd4, 1'b0};
    vecs[6] = '{3'd6, 4'b0000, 3'd0, 8'h00, 4'd0, 1'b1};
    vecs[7] = '{3'd7, 4'b0000, 3'd0, 8'h00, 4'd0, 1'b1};
    vecs[8] = '{3'd2, 4'b0111, 3'd3, 8'h7F, 4'd7, 1'b0};

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;

    // Every mode, back to back from DONE, ending with a legal one after illegal
    for (int vi = 0; vi < 9; vi++) begin
      applyStimulus(vi);
      checkOutput(vi);
    end

    // start held high with mode toggling: one NAND sweep, then restart from DONE
    toggles[0] = 3'd0; toggles[1] = 3'd6; toggles[2] = 3'd5; toggles[3] = 3'd1;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 3'd2;
    pushExpected(vecs[2], 1'b1, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      mode = toggles[i];
      @(posedge clk); #1;
    end
    check("hold dut2 done",  32'(bus2.done), 1);
    check("hold dut2 valid", 32'(bus2.valid), 1);
    check("hold dut2 table", 32'(bus2.truth_table), 32'(4'b0111));
    check("hold dut2 ones",  32'(bus2.ones), 3);
    check("hold dut3 busy",  32'(bus3.busy), 1);
    mode = 3'd4;
    pushExpected(vecs[4], 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("restart dut2 busy",  32'(bus2.busy), 1);
    check("restart dut2 done",  32'(bus2.done), 0);
    check("restart dut2 table", 32'(bus2.truth_table), 0);
    check("restart dut2 ones",  32'(bus2.ones), 0);
    waitDone();
    @(negedge clk); #1;
    drain();
    check("restart dut2 done cycle", 32'(d2), 4);
    check("hold dut3 done cycle",    32'(d3), 3);
    check("restart dut2 table XOR",  32'(bus2.truth_table), 32'(4'b0110));
    check("restart dut2 ones XOR",   32'(bus2.ones), 2);
    check("hold dut3 table NAND",    32'(bus3.truth_table), 32'(8'h7F));
    check("hold dut3 ones NAND",     32'(bus3.ones), 7);
    check("hold dut2 queue left",    32'(q2.size()), 0);
    check("hold dut3 queue left",    32'(q3.size()), 0);

    // Reset at the second sweep edge, then a clean sweep
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 3'd2;
    pushExpected(vecs[2], 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkReset();
    drain();
    check("midrst dut2 pairs left", 32'(q2.size()), 3);
    check("midrst dut3 pairs left", 32'(q3.size()), 7);
    q2.delete();
    q3.delete();
    applyStimulus(2);
    checkOutput(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_sweep_engine.md
GATE_SWEEP_ENGINE -- requirements
Module: gate_sweep_engine

Interface
REQ-001 SHALL have parameter N, default 2, legal range 1..6: number of gate inputs swept.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a full truth-table sweep.
REQ-005 SHALL have port mode  input  3  gate select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 illegal.
REQ-006 SHALL have port A  output  N  registered input vector applied to the gate, paired with Y.
REQ-007 SHALL have port Y  output  1  registered gate result for A.
REQ-008 SHALL have port valid  output  1  A/Y hold a fresh result this cycle.
REQ-009 SHALL have port table  output  2**N  accumulated truth table; bit i = result for input i.
REQ-010 SHALL have port ones  output  N+1  count of 1 results in table.
REQ-011 SHALL have port busy  output  1  sweep in progress.
REQ-012 SHALL have port done  output  1  sweep complete, results stable.
REQ-013 SHALL have port err  output  1  last start carried an illegal mode.

Function
REQ-014 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-015 SHALL, in IDLE or DONE, on start=1 with legal mode at edge E0: latch mode, clear table/ones/err, set index counter to 0, enter SWEEP.
REQ-016 SHALL, on start=1 with mode 6 or 7 at E0: enter DONE with err=1, table=0, ones=0, no valid pulses.
REQ-017 SHALL ignore start while in SWEEP; SHALL ignore mode changes after E0 (latched mode governs whole sweep).
REQ-018 SHALL, at each edge Ek (k=1..2**N) in SWEEP, register A=k-1, Y=gate(latched mode, reduction over bits of k-1), valid=1, table[k-1]=Y, ones=ones+Y.
REQ-019 SHALL, for N-input gates, apply reduction: AND/NAND all bits, OR/NOR any bit, XOR/XNOR odd parity (N=1 XNOR = NOT).
REQ-020 SHALL, at edge E(2**N) (counter = 2**N-1), enter DONE; done rises in the same cycle as the final valid.
REQ-021 SHALL drive valid=0 in every cycle not following a SWEEP edge; A/Y hold last value when valid=0.
REQ-022 SHALL drive busy=1 exactly in SWEEP; done=1 exactly in DONE; done held until next accepted start or rst.
REQ-023 SHALL keep table and ones stable in DONE; a new start restarts from REQ-015 (results cleared at E0).
REQ-024 SHALL size counter N+1 bits so no wrap occurs before the terminal comparison; ones never exceeds 2**N.
REQ-025 SHALL complete a legal sweep in exactly 2**N cycles from E0 to done.

Reset
REQ-026 SHALL, on rst=1 at any edge (including mid-SWEEP), force state IDLE, A=0, Y=0, valid=0, table=0, ones=0, busy=0, done=0, err=0, counter=0.
REQ-027 SHALL give rst priority over start in the same cycle.

Verification
REQ-028 N=2, mode=2 (NAND), start 1 cycle -> valid 4 cycles, (A,Y)=(00,1),(01,1),(10,1),(11,0); table=4'b0111, ones=3, done with last valid.
REQ-029 N=2, mode=4 (XOR) -> Y=0,1,1,0; table=4'b0110, ones=2, busy high 4 cycles.
REQ-030 N=3, mode=0 (AND) -> table=8'h80, ones=1, done 8 cycles after E0.
REQ-031 mode=6 start -> next cycle err=1, done=1, valid never high, table=0, ones=0.
REQ-032 start held high through sweep, mode toggled mid-sweep -> single NAND sweep, identical to REQ-028; start still high in DONE triggers restart with cleared table.
REQ-033 rst asserted at E2 of an N=2 sweep -> following cycle all outputs 0, IDLE; later start yields full correct sweep.
